// File: rtl/divu_hilo_unit.sv
// -----------------------------------------------------------------------------
// divu_hilo_unit
//
// Sequential unsigned restoring divider with the HI/LO result registers that
// sit behind it. A division starts when the ALU control block presents DIVU
// in IDLE. The unit then produces one quotient bit per clock for WIDTH clocks
// and waits in DONE. The result is committed to HI (remainder) and LO
// (quotient) only when HILO_OPEN is seen, or when it was already seen while
// the division was still running. MFHI/MFLO read HI/LO back onto dataOut.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   Signal   in   6-bit control code (DIVU, HILO_OPEN, MFHI, MFLO decoded)
//   dataA    in   dividend, sampled on the start edge only
//   dataB    in   divisor, sampled on the start edge only
//   dataOut  out  HI on MFHI, LO on MFLO, otherwise 0 (combinational read)
//   busy     out  division iterating
//   done     out  result computed, waiting for commit
//   divZero  out  committed result came from a zero divisor
// -----------------------------------------------------------------------------
module divu_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done,
    output logic             divZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [5:0] SIG_DIVU      = 6'b011011;
    localparam logic [5:0] SIG_HILO_OPEN = 6'b111111;
    localparam logic [5:0] SIG_MFHI      = 6'b010000;
    localparam logic [5:0] SIG_MFLO      = 6'b010010;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q,   state_d;
    logic [2*WIDTH-1:0] rq_q,      rq_d;      // {R, Q} working register
    logic [WIDTH-1:0]   div_q,     div_d;     // latched divisor
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic               pend_q,    pend_d;    // commit requested during RUN
    logic               dz_q,      dz_d;      // in-flight divisor was zero
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic               divzero_q, divzero_d;

    logic [WIDTH:0]     rem_ext_s;            // {R, Q msb}: shifted partial remainder
    logic [WIDTH-1:0]   diff_s;
    logic               ge_s;
    logic [2*WIDTH-1:0] step_s;
    logic               commit_s;

    // One restoring-division iteration on the working register.
    always_comb begin
        // Shifted remainder needs WIDTH+1 bits: R < D lets 2R+1 exceed WIDTH bits.
        rem_ext_s = rq_q[2*WIDTH-1:WIDTH-1];
        ge_s      = (rem_ext_s >= {1'b0, div_q});
        // When ge_s holds the true difference is below D, so WIDTH bits suffice.
        diff_s    = rem_ext_s[WIDTH-1:0] - div_q;
        if (ge_s) begin
            step_s = {diff_s, rq_q[WIDTH-2:0], 1'b1};
        end else begin
            step_s = {rem_ext_s[WIDTH-1:0], rq_q[WIDTH-2:0], 1'b0};
        end
    end

    // Control FSM and next-state values for all registers.
    always_comb begin
        state_d   = state_q;
        rq_d      = rq_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = divzero_q;
        commit_s  = pend_q || (Signal == SIG_HILO_OPEN);
        case (state_q)
            S_IDLE: begin
                if (Signal == SIG_DIVU) begin
                    rq_d    = {{WIDTH{1'b0}}, dataA};
                    div_d   = dataB;
                    dz_d    = (dataB == {WIDTH{1'b0}});
                    cnt_d   = {CW{1'b0}};
                    pend_d  = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                rq_d  = step_s;
                cnt_d = cnt_q + CW'(1);
                if (Signal == SIG_HILO_OPEN) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (commit_s) begin
                    hi_d      = rq_q[2*WIDTH-1:WIDTH];
                    lo_d      = rq_q[WIDTH-1:0];
                    divzero_d = dz_q;
                    pend_d    = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rq_q      <= {(2*WIDTH){1'b0}};
            div_q     <= {WIDTH{1'b0}};
            cnt_q     <= {CW{1'b0}};
            pend_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= {WIDTH{1'b0}};
            lo_q      <= {WIDTH{1'b0}};
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rq_q      <= rq_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divzero_q <= divzero_d;
        end
    end

    // Status decode from the state register.
    always_comb begin
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);
        divZero = divzero_q;
    end

    // HI/LO read mux; committed values only, no bypass of an in-flight commit.
    always_comb begin
        case (Signal)
            SIG_MFHI: dataOut = hi_q;
            SIG_MFLO: dataOut = lo_q;
            default:  dataOut = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: doc/divu_hilo_unit.md
# divu_hilo_unit

Sequential 32-bit unsigned divider with its HI/LO result registers, sitting directly downstream of the ALU control block on its divider-control bus. It starts a restoring division when the control code DIVU (6'b011011) is presented. It produces one quotient bit per clock. It commits remainder and quotient to HI/LO only when the control block issues the HiLo-open code 6'b111111. MFHI and MFLO read the stored results back onto the datapath mux.

## Interface
- WIDTH, 32: operand, quotient and remainder width; iteration count equals WIDTH.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- Signal  in  6  control code from ALU control; decoded values are DIVU=6'b011011, HILO_OPEN=6'b111111, MFHI=6'b010000 and MFLO=6'b010010.
- dataA  in  WIDTH  dividend, sampled only on the start edge.
- dataB  in  WIDTH  divisor, sampled only on the start edge.
- dataOut  out  WIDTH  HI when Signal==MFHI, LO when Signal==MFLO, else 0 (combinational on Signal and registered HI/LO).
- busy  out  1  high while in RUN.
- done  out  1  high while in DONE (result computed, not yet committed).
- divZero  out  1  registered; set with the HI/LO commit of a division whose divisor was 0, cleared with the commit of a nonzero-divisor division.

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE
  - On an edge where Signal==DIVU: load the 2*WIDTH working register {R,Q} with {0,dataA}, latch divisor D=dataB, latch dz=(dataB==0), set cnt=0, clear pend, go to RUN.
  - All other codes leave state unchanged.
- RUN, each edge:
  - t={R,Q}<<1.
  - If t[2W-1:W] >= D: upper half becomes t_upper-D and Q[0]=1; else t is kept with Q[0]=0.
  - Compare and subtract are WIDTH+1 bits wide so no carry is lost.
  - cnt increments; on the edge where cnt==WIDTH-1 go to DONE.
  - Signal changes, including DIVU and dataA/dataB changes, do not disturb the running division.
  - Signal==HILO_OPEN sampled in RUN sets pend.
- DONE
  - If pend is set, or Signal==HILO_OPEN on the edge: HI<=R, LO<=Q, divZero<=dz, clear pend, go to IDLE.
  - Otherwise hold; all other codes, including DIVU, are ignored until commit.
- Divide by zero: no special path. The algorithm yields Q=all ones and R=dataA; only divZero marks it.
- HI/LO change only on a commit edge. They are never written by MFHI/MFLO or by any other code.
- Reset, including mid-RUN or in DONE:
  - State goes to IDLE; HI, LO, R, Q, D, cnt, pend, dz and divZero are cleared to 0.
  - The in-flight result is discarded.

## Timing
- Start edge E0, where DIVU is sampled in IDLE. RUN iterations occur on E1..E32, with busy high after E0 through E32.
- done is high after E32.
- Commit edge is E33 at the earliest, either from pend or from HILO_OPEN sampled at E33. Otherwise commit occurs at the first later edge with HILO_OPEN.
- New HI/LO values are visible on dataOut from the cycle after the commit edge. A read in the commit cycle returns the old value (no bypass).
- A new DIVU is accepted on the edge after commit at the earliest, giving a back-to-back throughput of 34 cycles.
- Reset values: busy=0, done=0, divZero=0, dataOut=0 for any non-MF code; HI=LO=0, so MFHI and MFLO return 0.
- Simultaneous cases:
  - HILO_OPEN at E32 sets pend, and the commit occurs at E33.
  - HILO_OPEN sampled in IDLE is ignored and commits nothing.

## Test plan
- Basic divide: 100 / 7 with DIVU, then HILO_OPEN at E33 -> LO=14, HI=2, divZero=0; MFLO drives 14 and MFHI drives 2 from E34.
- Full range: 0xFFFFFFFF / 1 -> LO=0xFFFFFFFF, HI=0. Then 5 / 0xFFFFFFFF -> LO=0, HI=5. Checks the (W+1)-bit compare.
- Divide by zero: 5 / 0 -> LO=0xFFFFFFFF, HI=5, divZero=1. A following 9 / 3 commit -> LO=3, HI=0, divZero=0.
- Early open:
  - HILO_OPEN pulsed at E10, then DIVU held -> commit at E33 automatically.
  - dataA/dataB changed during RUN -> no effect on the result.
- Hold in DONE: no HILO_OPEN for 20 cycles, with DIVU held -> done stays 1 and HI/LO are unchanged; commit happens on the eventual HILO_OPEN.
- Reset: rst_n low at E15 of 100/7 -> busy=0, done=0 and HI=LO=0 immediately (asynchronous); the next DIVU runs a clean division.
